// File: rtl/ddr_pkg.sv
// Shared DDR write-side definitions: FSM state encoding and DDR port widths.
// Pure declarations; no logic, no latency, no flow control.
package ddr_pkg;

    localparam int DDR_LEN_W  = 10;
    localparam int DDR_DATA_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_DATA     = 3'd2,
        ST_WAIT_FIN = 3'd3,
        ST_NEXT     = 3'd4
    } state_t;

endpackage

// File: rtl/ddr_wr_burst_ctrl.sv
// Drains the video write FIFO into fixed-length DDR write bursts with frame-linear addressing.
// rd_en is combinational on wr_burst_data_req (data 1 cycle later); bursts start only with BURST_LEN words buffered.
module ddr_wr_burst_ctrl
    import ddr_pkg::*;
#(
    parameter int BURST_LEN   = 128,
    parameter int LEVEL_W     = 10,
    parameter int ADDR_W      = 28,
    parameter int FRAME_BASE  = 0,
    parameter int FRAME_WORDS = 393216
) (
    input  logic                  mem_clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [LEVEL_W-1:0]    rd_water_level,
    output logic                  rd_en,
    input  logic [DDR_DATA_W-1:0] rd_data,
    output logic                  wr_burst_req,
    output logic [DDR_LEN_W-1:0]  wr_burst_len,
    output logic [ADDR_W-1:0]     wr_burst_addr,
    input  logic                  wr_burst_data_req,
    output logic [DDR_DATA_W-1:0] wr_burst_data,
    input  logic                  wr_burst_finish,
    output logic                  busy,
    output logic                  overrun_err
);

    localparam int                 CNT_W  = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0]   LAST   = CNT_W'(BURST_LEN);
    localparam logic [LEVEL_W-1:0] LVL_TH = LEVEL_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0]  BASE_A = ADDR_W'(FRAME_BASE);
    localparam logic [ADDR_W-1:0]  END_A  = ADDR_W'(FRAME_BASE + FRAME_WORDS);
    localparam logic [ADDR_W-1:0]  STEP_A = ADDR_W'(BURST_LEN);

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   beat_cnt;
    logic               pend_frame;
    logic               fin_early;

    logic               beat_ok;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [ADDR_W-1:0]  addr_inc;

    // Beats are only honoured while a burst is open and the per-burst cap is not hit,
    // which is what makes FIFO underflow impossible.
    assign beat_ok  = wr_burst_data_req && (beat_cnt < LAST) &&
                      ((state == ST_REQ) || (state == ST_DATA));
    assign cnt_nxt  = beat_cnt + {{(CNT_W-1){1'b0}}, beat_ok};
    assign addr_inc = addr + STEP_A;

    assign rd_en         = beat_ok;
    assign wr_burst_req  = (state == ST_REQ);
    assign wr_burst_addr = addr;
    assign wr_burst_len  = DDR_LEN_W'(BURST_LEN);
    assign wr_burst_data = rd_data;
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr        <= BASE_A;
            beat_cnt    <= '0;
            pend_frame  <= 1'b0;
            fin_early   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start)
                        addr <= BASE_A;
                    if (rd_water_level >= LVL_TH)
                        state <= ST_REQ;
                end
                ST_REQ: begin
                    if (wr_burst_data_req) begin
                        beat_cnt <= cnt_nxt;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    beat_cnt <= cnt_nxt;
                    // An early finish is remembered so WAIT_FIN does not wait for a second one.
                    if (wr_burst_finish) begin
                        fin_early <= 1'b1;
                        if (cnt_nxt != LAST)
                            overrun_err <= 1'b1;
                        state <= ST_WAIT_FIN;
                    end else if (cnt_nxt == LAST) begin
                        state <= ST_WAIT_FIN;
                    end
                end
                ST_WAIT_FIN: begin
                    if (wr_burst_data_req)
                        overrun_err <= 1'b1;
                    if (wr_burst_finish || fin_early) begin
                        if (beat_cnt != LAST)
                            overrun_err <= 1'b1;
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (pend_frame || frame_start || (addr_inc == END_A))
                        addr <= BASE_A;
                    else
                        addr <= addr_inc;
                    pend_frame <= 1'b0;
                    fin_early  <= 1'b0;
                    beat_cnt   <= '0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // A frame restart never aborts the running burst; it retargets the next one.
            if (frame_start && (state != ST_IDLE) && (state != ST_NEXT))
                pend_frame <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Scoreboard bench: FIFO + DDR controller models, expected beats/addresses queued at stimulus time.
module tb_ddr_wr_burst_ctrl;

    localparam int BL = 128;
    localparam int FW = 512;

    logic        mem_clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [9:0]  rd_water_level = '0;
    logic        rd_en;
    logic [63:0] rd_data;
    logic        wr_burst_req;
    logic [9:0]  wr_burst_len;
    logic [27:0] wr_burst_addr;
    logic        wr_burst_data_req;
    logic [63:0] wr_burst_data;
    logic        wr_burst_finish;
    logic        busy;
    logic        overrun_err;

    ddr_wr_burst_ctrl #(
        .BURST_LEN(BL), .LEVEL_W(10), .ADDR_W(28), .FRAME_BASE(0), .FRAME_WORDS(FW)
    ) dut (
        .mem_clk(mem_clk), .rst(rst), .frame_start(frame_start),
        .rd_water_level(rd_water_level), .rd_en(rd_en), .rd_data(rd_data),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
        .wr_burst_addr(wr_burst_addr), .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_data(wr_burst_data), .wr_burst_finish(wr_burst_finish),
        .busy(busy), .overrun_err(overrun_err)
    );

    always #5 mem_clk = ~mem_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] fifo_q[$];
    logic [63:0] exp_data[$];
    logic [27:0] exp_addr[$];
    int          model_addr = 0;
    int          rden_cnt = 0;
    bit          ovr_seen[0:255];
    logic        take;
    logic        req_prev = 1'b0;
    logic        rde_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [63:0] w);
        fifo_q.push_back(w);
        exp_data.push_back(w);
    endtask

    // Reference address rule: advance one burst within the frame, or restart on frame_start.
    task automatic model_next(input bit fs);
        model_addr = fs ? 0 : (model_addr + BL) % FW;
    endtask

    // FIFO model: a read accepted at an edge presents its word one cycle later.
    always begin
        @(negedge mem_clk); #3;
        take = rd_en;
        @(posedge mem_clk); #1;
        if (take === 1'b1) begin
            if (fifo_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL fifo_underflow: read with 0 words, required level >= 1");
            end else begin
                rd_data = fifo_q.pop_front();
            end
        end
        rd_water_level = 10'(fifo_q.size());
    end

    // Monitor: the controller samples beat data the cycle after each accepted beat.
    always begin
        @(negedge mem_clk); #3;
        if (rst) begin
            req_prev = 1'b0;
            rde_prev = 1'b0;
        end else begin
            if (rde_prev) begin
                if (exp_data.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL beat_data: got 0x%0h, expected none", wr_burst_data);
                end else begin
                    check("beat_data", wr_burst_data, exp_data.pop_front());
                end
            end
            if (wr_burst_req && !req_prev) begin
                if (exp_addr.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL burst_addr: got 0x%0h, expected no burst", wr_burst_addr);
                end else begin
                    check("burst_addr", 64'(wr_burst_addr), 64'(exp_addr.pop_front()));
                end
                check("burst_len", 64'(wr_burst_len), 64'(BL));
            end
            if (rd_en) rden_cnt++;
            req_prev = wr_burst_req;
            rde_prev = rd_en;
        end
    end

    // Controller model: data_req 4 cycles after req, 'beats' consecutive beats, finish 3 cycles later.
    task automatic ctrl_burst(input int beats, input int fs_beat, input int rst_beat, input bit chk_busy);
        bit got = 0;
        rden_cnt = 0;
        for (int t = 0; t < 3000 && !got; t++) begin
            @(negedge mem_clk); #3;
            got = wr_burst_req;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL req_timeout: wr_burst_req 0 after 3000 cycles, required 1");
            return;
        end
        repeat (3) @(negedge mem_clk);
        for (int i = 0; i < beats; i++) begin
            @(negedge mem_clk);
            if (i == rst_beat) begin
                wr_burst_data_req = 1'b0;
                frame_start = 1'b0;
                rst = 1'b1;
                #1;
                check("rst_rd_en", 64'(rd_en), 64'(0));
                check("rst_req", 64'(wr_burst_req), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_overrun", 64'(overrun_err), 64'(0));
                check("rst_addr", 64'(wr_burst_addr), 64'(0));
                fifo_q.delete();
                exp_data.delete();
                return;
            end
            wr_burst_data_req = 1'b1;
            frame_start = (i == fs_beat);
            #3;
            ovr_seen[i] = overrun_err;
        end
        @(negedge mem_clk);
        wr_burst_data_req = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(negedge mem_clk);
        wr_burst_finish = 1'b1;
        @(negedge mem_clk);
        wr_burst_finish = 1'b0;
        #3;
        if (chk_busy) check("busy_fin_plus1", 64'(busy), 64'(1));
        @(negedge mem_clk); #3;
        if (chk_busy) check("busy_fin_plus2", 64'(busy), 64'(0));
    endtask

    initial begin
        int seen_req;
        int seen_rden;
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "bench timeout");
    end

    initial begin
        int seen_req, seen_rden;
        rst = 1'b1;
        frame_start = 1'b0;
        wr_burst_data_req = 1'b0;
        wr_burst_finish = 1'b0;
        rd_data = '0;
        repeat (3) @(negedge mem_clk);
        #3;
        check("reset_req", 64'(wr_burst_req), 64'(0));
        check("reset_rd_en", 64'(rd_en), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_overrun", 64'(overrun_err), 64'(0));
        check("reset_len", 64'(wr_burst_len), 64'(BL));
        check("reset_addr", 64'(wr_burst_addr), 64'(0));
        @(negedge mem_clk);
        rst = 1'b0;

        // Counting pattern: 32-bit words 1024..1535 packed low-word-first.
        for (int k = 0; k < 256; k++) begin
            logic [31:0] lo, hi;
            lo = 32'(1024 + 2 * k);
            hi = 32'(1025 + 2 * k);
            push_word({hi, lo});
        end
        exp_addr.push_back(28'(model_addr));
        ctrl_burst(128, -1, -1, 1'b1);
        model_next(1'b0);
        check("b0_rden_cnt", 64'(rden_cnt), 64'(128));
        check("b0_level_after", 64'(rd_water_level), 64'(128));

        // Four more bursts, wrapping the 512-word frame back to 0.
        for (int k = 0; k < 384; k++) push_word({$urandom, $urandom});
        for (int b = 0; b < 4; b++) begin
            exp_addr.push_back(28'(model_addr));
            ctrl_burst(128, -1, -1, 1'b1);
            model_next(1'b0);
            check("seq_rden_cnt", 64'(rden_cnt), 64'(128));
        end
        check("seq_overrun", 64'(overrun_err), 64'(0));

        // Level one short of a burst must never start one.
        for (int k = 0; k < 127; k++) push_word({$urandom, $urandom});
        seen_req = 0;
        seen_rden = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge mem_clk); #3;
            if (wr_burst_req) seen_req++;
            if (rd_en) seen_rden++;
        end
        check("lvl127_req", 64'(seen_req), 64'(0));
        check("lvl127_rden", 64'(seen_rden), 64'(0));
        exp_addr.push_back(28'(model_addr));
        @(negedge mem_clk);
        push_word({$urandom, $urandom});
        #3;
        @(negedge mem_clk); #3;
        check("lvl128_req_idle", 64'(wr_burst_req), 64'(0));
        @(negedge mem_clk); #3;
        check("lvl128_req_next", 64'(wr_burst_req), 64'(1));

        // frame_start mid-burst at addr 128: burst completes, next one restarts at 0.
        ctrl_burst(128, 10, -1, 1'b1);
        model_next(1'b1);
        check("fs_rden_cnt", 64'(rden_cnt), 64'(128));
        for (int k = 0; k < 128; k++) push_word({$urandom, $urandom});
        exp_addr.push_back(28'(model_addr));
        ctrl_burst(128, -1, -1, 1'b1);
        model_next(1'b0);

        // 130 beats requested: 128 honoured, overrun on the 129th.
        for (int k = 0; k < 128; k++) push_word({$urandom, $urandom});
        exp_addr.push_back(28'(model_addr));
        ctrl_burst(130, -1, -1, 1'b1);
        check("ovr_rden_cnt", 64'(rden_cnt), 64'(128));
        check("ovr_after_128", 64'(ovr_seen[128]), 64'(0));
        check("ovr_after_129", 64'(ovr_seen[129]), 64'(1));
        @(negedge mem_clk);
        rst = 1'b1;
        fifo_q.delete();
        exp_data.delete();
        model_addr = 0;
        @(negedge mem_clk);
        rst = 1'b0;
        #3;
        check("ovr_cleared", 64'(overrun_err), 64'(0));

        // Reset at beat 50, then a clean burst at 0 after refill.
        for (int k = 0; k < 128; k++) push_word({$urandom, $urandom});
        exp_addr.push_back(28'(model_addr));
        ctrl_burst(128, -1, 50, 1'b0);
        @(negedge mem_clk);
        rst = 1'b0;
        model_addr = 0;
        repeat (2) @(negedge mem_clk);
        for (int k = 0; k < 128; k++) push_word({$urandom, $urandom});
        exp_addr.push_back(28'(model_addr));
        ctrl_burst(128, -1, -1, 1'b1);
        model_next(1'b0);
        check("post_rst_rden_cnt", 64'(rden_cnt), 64'(128));

        // Early finish after 100 beats flags overrun and still returns to idle.
        for (int k = 0; k < 128; k++) push_word({$urandom, $urandom});
        exp_addr.push_back(28'(model_addr));
        ctrl_burst(100, -1, -1, 1'b0);
        check("early_rden_cnt", 64'(rden_cnt), 64'(100));
        repeat (5) @(negedge mem_clk);
        #3;
        check("early_overrun", 64'(overrun_err), 64'(1));
        check("early_busy", 64'(busy), 64'(0));
        check("addr_queue_empty", 64'(exp_addr.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
